// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one pipelined multiplier among N_REQ requesters
// and returns each product tagged with the ID of the requester that issued it.
module mult_arbiter #(
    parameter int N_REQ = 4,
    parameter int M_W   = 8,
    parameter int N_W   = 8,
    parameter int LAT   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*M_W-1:0]      req_a,
    input  logic [N_REQ*N_W-1:0]      req_b,
    output logic [M_W-1:0]            mul_a,
    output logic [N_W-1:0]            mul_b,
    input  logic [M_W+N_W-1:0]        mul_out,
    output logic                      rsp_valid,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic [M_W+N_W-1:0]        rsp_data,
    output logic                      busy
);

    localparam int ID_W = $clog2(N_REQ);

    logic [M_W-1:0]  req_a_arr [N_REQ];
    logic [N_W-1:0]  req_b_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_a_arr[i] = req_a[i*M_W +: M_W];
        assign req_b_arr[i] = req_b[i*N_W +: N_W];
    end

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [M_W-1:0]  mul_a_q, mul_a_d;
    logic [N_W-1:0]  mul_b_q, mul_b_d;
    // Stage 0 runs alongside the operand register, stages 1..LAT alongside the multiplier.
    logic [LAT:0]            tag_vld_q, tag_vld_d;
    logic [LAT:0][ID_W-1:0]  tag_id_q, tag_id_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] scan_idx;

    // NOTE: combinational blocks use blocking assignments with every output defaulted
    // first, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int off = 0; off < N_REQ; off++) begin
            scan_idx = ID_W'((int'(ptr_q) + off) % N_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        if (rst) begin
            grant_found = 1'b0;
        end
        req_ready = grant_found ? (N_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        ptr_d     = ptr_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        tag_vld_d = {tag_vld_q[LAT-1:0], grant_found};
        tag_id_d  = {tag_id_q[LAT-1:0], grant_idx};
        if (grant_found) begin
            ptr_d   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            mul_a_d = req_a_arr[grant_idx];
            mul_b_d = req_b_arr[grant_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            tag_vld_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            tag_vld_q <= tag_vld_d;
        end
    end

    // NOTE: tag IDs are qualified by their valid bits, so they carry no reset and
    // stay in their own block rather than picking up a reset-dependent enable.
    always_ff @(posedge clk) begin
        tag_id_q <= tag_id_d;
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = tag_vld_q[LAT];
    assign rsp_id    = tag_id_q[LAT];
    assign rsp_data  = mul_out;
    assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural LAT-stage multiplier and a
// scoreboard that predicts every response's ID, product and arrival cycle.
module tb_mult_arbiter;

    localparam int N_REQ = 4;
    localparam int M_W   = 8;
    localparam int N_W   = 8;
    localparam int LAT   = 3;
    localparam int ID_W  = 2;
    localparam int P_W   = M_W + N_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*M_W-1:0] req_a;
    logic [N_REQ*N_W-1:0] req_b;
    logic [M_W-1:0]       mul_a;
    logic [N_W-1:0]       mul_b;
    logic [P_W-1:0]       mul_out;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [P_W-1:0]       rsp_data;
    logic                 busy;

    mult_arbiter #(.N_REQ(N_REQ), .M_W(M_W), .N_W(N_W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_out   (mul_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Unsigned multiplier with LAT register stages behind the operand ports.
    logic [P_W-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= P_W'(mul_a) * P_W'(mul_b);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_out = mpipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int             id;
        logic [P_W-1:0] data;
        int             due;
    } exp_t;

    exp_t sb_q[$];
    logic mon_en = 1'b0;

    // Scoreboard: push on each handshake, pop and compare when a response arrives.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_busy;
            exp_t e;
            exp_busy = 1'b0;
            foreach (sb_q[k]) if (sb_q[k].due - LAT <= cyc) exp_busy = 1'b1;
            check("busy", 32'(busy), 32'(exp_busy));
            check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (rsp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                check("rsp_missing", 32'(rsp_valid), 32'd1);
                void'(sb_q.pop_front());
            end
            if (rst) sb_q.delete();
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id   = i;
                    e.data = P_W'(req_a[i*M_W +: M_W]) * P_W'(req_b[i*N_W +: N_W]);
                    e.due  = cyc + 1 + LAT;
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*M_W +: M_W] = M_W'(a);
        req_b[i*N_W +: N_W] = N_W'(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb_q.size() > 0; k++) tick();
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [N_REQ-1:0] exp_rdy;
        rst = 1'b1;
        req_valid = 4'b1111;
        req_a = '0;
        req_b = '0;
        tick();
        tick();
        mon_en = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        req_valid = '0;
        tick();
        rst = 1'b0;

        // Single operation from requester 0.
        req_valid = 4'b0001;
        set_req(0, 3, 5);
        #1;
        check("t1_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        check("t1_mul_a", 32'(mul_a), 32'd3);
        check("t1_mul_b", 32'(mul_b), 32'd5);
        drain();

        // Pointer at 1 after a grant to 0: requesters 0 and 3 -> 3 then 0.
        req_valid = 4'b0001;
        set_req(0, 7, 9);
        #1;
        check("t4_first0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b1001;
        set_req(3, 11, 13);
        #1;
        check("t4_grant3", 32'(req_ready), 32'b1000);
        tick();
        #1;
        check("t4_grant0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        drain();

        // All four continuously valid: strict rotation from ptr=0.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, i + 1, 10);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            exp_rdy = N_REQ'(1) << (c % N_REQ);
            #1;
            check("t2_rotate", 32'(req_ready), 32'(exp_rdy));
            tick();
        end
        req_valid = '0;
        drain();

        // Requester 2 alone: granted every cycle, no bubbles.
        req_valid = 4'b0100;
        for (int c = 1; c <= 5; c++) begin
            set_req(2, c, 2);
            #1;
            check("t3_ready", 32'(req_ready), 32'b0100);
            tick();
        end
        req_valid = '0;
        drain();

        // Reset with four operations in flight.
        for (int i = 0; i < N_REQ; i++) set_req(i, 20 + i, 3);
        req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        #1;
        check("t5_ready_in_rst", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < LAT + 3; c++) begin
            check("t5_no_rsp", 32'(rsp_valid), 32'd0);
            check("t5_not_busy", 32'(busy), 32'd0);
            tick();
        end
        req_valid = 4'b1010;
        #1;
        check("t5_first_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        drain();

        // Exhaustive operand sweep through requester 1.
        req_valid = 4'b0010;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                set_req(1, a, b);
                tick();
            end
        end
        req_valid = '0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
